muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   Sits beside the combinational ALU in EX. Takes SrcA/SrcB, runs MULTU/DIVU
//   over WIDTH cycles and returns results through HI/LO for MFHI/MFLO.
//   Provides a start/busy/done handshake so the pipeline controller can stall.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are WIDTH bits each (product 2*WIDTH)
//   CNT_W  $clog2(WIDTH)  iteration counter width (derived, do not override)
// PORTS
//   clk    in   1      clock; all state updates on rising edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only while busy=0
//   op     in   3      000 MULTU, 001 DIVU, 010 MULT, 011 DIV, 100 MTHI, 101 MTLO
//   SrcA   in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//   SrcB   in   WIDTH  multiplier / divisor
//   busy   out  1      operation in flight; start ignored
//   done   out  1      one-cycle pulse: HI/LO hold the new result
//   HI     out  WIDTH  high product / remainder
//   LO     out  WIDTH  low product / quotient
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0. Reset mid-operation
//     aborts it; no partial result is ever written to HI/LO.
//   FSM: IDLE -> MUL | DIV on start with a valid MUL/DIV op; MUL/DIV -> IDLE after
//     WIDTH iterations. MTHI/MTLO never leave IDLE.
//   MTHI/MTLO (start=1, busy=0): HI or LO <= SrcA at that edge. Other register
//     unchanged. No busy. No done.
//   MUL/DIV accept edge E0: operands latched, busy=1 after E0, counter=0.
//     One iteration per cycle. At edge E0+WIDTH HI/LO take the final result,
//     done=1 and busy=0 for exactly that cycle. Latency = WIDTH cycles.
//   MULTU: radix-2 shift-add on a 2*WIDTH accumulator; {HI,LO} = SrcA*SrcB (unsigned).
//   DIVU: restoring division, one quotient bit per cycle, MSB first.
//     LO = SrcA/SrcB, HI = SrcA%SrcB.
//   Divide by zero is not trapped and runs full latency.
//     Result is LO = all ones, HI = SrcA.
//   start while busy=1: ignored, including MTHI/MTLO. Operands and op are not latched.
//   start in the done cycle (busy=0): accepted. This allows back-to-back operations.
//   Undefined op codes (110, 111): ignored, no state change.
//   HI/LO are stable at all times except at the MTHI/MTLO edge and the completion edge.
//     They are readable while busy and show the previous values.
// CONFIGURATION
//   SIGNED_MULDIV_EN defined: op 010 MULT and 011 DIV are signed.
//     Operands are converted to magnitudes when latched.
//     The unsigned core runs with no extra cycles.
//     Signs are fixed when the result is written at completion:
//     the product is negated if the operand signs differ; the quotient is negated
//     if the signs differ; the remainder takes the sign of the dividend.
//     Signed divide by zero gives LO = all ones and HI = SrcA.
//   SIGNED_MULDIV_EN undefined: op 010 and 011 are treated as undefined and ignored.
//     No sign-fix logic is built.
// TESTING
//   MULTU 7*6 -> done exactly 32 cycles after accept; HI=0x00000000, LO=0x0000002A.
//   MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//   DIVU 100/7 -> LO=0x0000000E, HI=0x00000002.
//   DIVU 0x12345678/0 -> LO=0xFFFFFFFF, HI=0x12345678.
//   Busy protection: start DIVU, then MTHI 0xDEAD and MULTU while busy ->
//     both ignored; DIVU result intact.
//   Back-to-back: MTLO 0x55 in the done cycle -> LO=0x55 next cycle.
//   Reset mid-op: assert rst at iteration 10 of MULTU 3*3 ->
//     HI=LO=0, busy=0, no done pulse.
//   SIGNED_MULDIV_EN: DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     MULT -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit owning the HI/LO pair, with a start/busy/done handshake.
// Build option: define SIGNED_MULDIV_EN to add signed MULT/DIV (ops 010/011) on top of the unsigned core.
module muldiv_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;

   localparam logic [2:0] OP_MULTU = 3'b000;
   localparam logic [2:0] OP_DIVU  = 3'b001;
   localparam logic [2:0] OP_MULT  = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   state_t             r_state;
   state_t             w_nextState;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_startMul;
   logic               w_startDiv;
   logic               w_writeHi;
   logic               w_writeLo;
   logic               w_last;
   logic [WIDTH-1:0]   w_magA;
   logic [WIDTH-1:0]   w_magB;
   logic [WIDTH:0]     w_mulSum;
   logic [2*WIDTH-1:0] w_mulNext;
   logic [WIDTH:0]     w_divShift;
   logic               w_divGe;
   logic [WIDTH-1:0]   w_divRem;
   logic [2*WIDTH-1:0] w_divNext;
   logic [2*WIDTH-1:0] w_prodRes;
   logic [WIDTH-1:0]   w_quotRes;
   logic [WIDTH-1:0]   w_remRes;

`ifdef SIGNED_MULDIV_EN
   logic               w_signedOp;
   logic               r_negProd;
   logic               r_negQuot;
   logic               r_negRem;
`endif

   // Requests are only decoded while idle; anything arriving during an operation is dropped.
   always_comb begin
      w_startMul = 1'b0;
      w_startDiv = 1'b0;
      w_writeHi  = 1'b0;
      w_writeLo  = 1'b0;
`ifdef SIGNED_MULDIV_EN
      w_signedOp = 1'b0;
`endif
      if (start && (r_state == S_IDLE)) begin
         case (op)
            OP_MULTU: w_startMul = 1'b1;
            OP_DIVU:  w_startDiv = 1'b1;
`ifdef SIGNED_MULDIV_EN
            OP_MULT: begin
               w_startMul = 1'b1;
               w_signedOp = 1'b1;
            end
            OP_DIV: begin
               w_startDiv = 1'b1;
               w_signedOp = 1'b1;
            end
`endif
            OP_MTHI:  w_writeHi = 1'b1;
            OP_MTLO:  w_writeLo = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef SIGNED_MULDIV_EN
   assign w_magA = (w_signedOp && SrcA[WIDTH-1]) ? -SrcA : SrcA;
   assign w_magB = (w_signedOp && SrcB[WIDTH-1]) ? -SrcB : SrcB;
`else
   assign w_magA = SrcA;
   assign w_magB = SrcB;
`endif

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   // Multiply: multiplier sits in the low half and shifts out LSB first while the product grows in the high half.
   assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
   assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

   // Divide: remainder in the high half, dividend bits leave the low half MSB first as quotient bits enter.
   assign w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_divGe    = (w_divShift >= {1'b0, r_opnd});
   assign w_divRem   = w_divGe ? WIDTH'(w_divShift - {1'b0, r_opnd}) : w_divShift[WIDTH-1:0];
   assign w_divNext  = {w_divRem, r_acc[WIDTH-2:0], w_divGe};

`ifdef SIGNED_MULDIV_EN
   assign w_prodRes = r_negProd ? -w_mulNext : w_mulNext;
   assign w_quotRes = r_negQuot ? -w_divNext[WIDTH-1:0] : w_divNext[WIDTH-1:0];
   assign w_remRes  = r_negRem  ? -w_divNext[2*WIDTH-1:WIDTH] : w_divNext[2*WIDTH-1:WIDTH];
`else
   assign w_prodRes = w_mulNext;
   assign w_quotRes = w_divNext[WIDTH-1:0];
   assign w_remRes  = w_divNext[2*WIDTH-1:WIDTH];
`endif

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_startMul) begin
               w_nextState = S_MUL;
            end else if (w_startDiv) begin
               w_nextState = S_DIV;
            end
         end
         S_MUL, S_DIV: begin
            if (w_last) begin
               w_nextState = S_IDLE;
            end
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // HI/LO only change on an MTHI/MTLO accept or on the final iteration, so a reset mid-operation never exposes a partial result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_acc  <= '0;
         r_opnd <= '0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_startMul) begin
            r_acc  <= {{WIDTH{1'b0}}, w_magB};
            r_opnd <= w_magA;
            r_cnt  <= '0;
         end else if (w_startDiv) begin
            r_acc  <= {{WIDTH{1'b0}}, w_magA};
            r_opnd <= w_magB;
            r_cnt  <= '0;
         end else if (r_state == S_MUL) begin
            r_acc <= w_mulNext;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_hi   <= w_prodRes[2*WIDTH-1:WIDTH];
               r_lo   <= w_prodRes[WIDTH-1:0];
               r_done <= 1'b1;
               r_cnt  <= '0;
            end
         end else if (r_state == S_DIV) begin
            r_acc <= w_divNext;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
               r_hi   <= w_remRes;
               r_lo   <= w_quotRes;
               r_done <= 1'b1;
               r_cnt  <= '0;
            end
         end
         if (w_writeHi) begin
            r_hi <= SrcA;
         end
         if (w_writeLo) begin
            r_lo <= SrcA;
         end
      end
   end

`ifdef SIGNED_MULDIV_EN
   // Quotient is left un-negated for a zero divisor so divide-by-zero still yields all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_negProd <= 1'b0;
         r_negQuot <= 1'b0;
         r_negRem  <= 1'b0;
      end else if (w_startMul || w_startDiv) begin
         r_negProd <= w_signedOp && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
         r_negQuot <= w_signedOp && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) && (SrcB != '0);
         r_negRem  <= w_signedOp && SrcA[WIDTH-1];
      end
   end
`endif

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: random and directed requests against an arithmetic reference model,
// with completions checked by a queue-based scoreboard monitor.
module tb_muldiv_unit;

   localparam int WIDTH = 32;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        busy;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          doneCycle;
   } exp_t;

   exp_t        sbQ[$];
   int          cycle = 0;
   int          checks = 0;
   int          failures = 0;

   // Reference model state: values visible on HI/LO now, and the result of the operation in flight.
   logic [31:0] mVisHi = '0;
   logic [31:0] mVisLo = '0;
   logic [31:0] mPendHi = '0;
   logic [31:0] mPendLo = '0;
   bit          mPending = 1'b0;
   int          mDoneCycle = 0;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .SrcA  (SrcA),
      .SrcB  (SrcB),
      .busy  (busy),
      .done  (done),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d actual=%h required=%h", name, cycle, act, exp);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest outstanding result, on time.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sbQ.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            e = sbQ.pop_front();
            check("sb_hi", HI, e.hi);
            check("sb_lo", LO, e.lo);
            check("sb_latency", 32'(cycle), 32'(e.doneCycle));
         end
      end
   end

   task automatic pushResult(input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      mPending   = 1'b1;
      mPendHi    = hi;
      mPendLo    = lo;
      mDoneCycle = cycle + WIDTH + 1;
      e.hi = hi;
      e.lo = lo;
      e.doneCycle = mDoneCycle;
      sbQ.push_back(e);
   endtask

   task automatic modelAccept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        p;
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic signed [63:0] sq;
      logic signed [63:0] sr;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (o)
         3'b000: begin
            p = {32'b0, a} * {32'b0, b};
            pushResult(p[63:32], p[31:0]);
         end
         3'b001: begin
            if (b == 0) pushResult(a, 32'hFFFF_FFFF);
            else pushResult(a % b, a / b);
         end
`ifdef SIGNED_MULDIV_EN
         3'b010: begin
            sq = sa * sb;
            pushResult(sq[63:32], sq[31:0]);
         end
         3'b011: begin
            if (b == 0) begin
               pushResult(a, 32'hFFFF_FFFF);
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               pushResult(sr[31:0], sq[31:0]);
            end
         end
`endif
         3'b100: mVisHi = a;
         3'b101: mVisLo = a;
         default: ;
      endcase
   endtask

   task automatic checkOutput(input bit expDone);
      check("busy", 32'(busy), 32'(mPending));
      check("done", 32'(done), 32'(expDone));
      check("hi_visible", HI, mVisHi);
      check("lo_visible", LO, mVisLo);
   endtask

   // One cycle: retire a completing result in the model, check outputs, then drive the next request.
   task automatic applyStimulus(input bit st, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      bit justDone;
      @(negedge clk);
      justDone = 1'b0;
      if (mPending && cycle >= mDoneCycle) begin
         mVisHi   = mPendHi;
         mVisLo   = mPendLo;
         mPending = 1'b0;
         justDone = 1'b1;
      end
      checkOutput(justDone);
      start = st;
      op    = o;
      SrcA  = a;
      SrcB  = b;
      if (st && !rst && !mPending) modelAccept(o, a, b);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'b000, '0, '0);
   endtask

   task automatic waitDone();
      while (mPending && cycle < mDoneCycle - 1) idle();
   endtask

   task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      applyStimulus(1'b1, o, a, b);
      waitDone();
      idle();
   endtask

   task automatic expectRegs(input string name, input logic [31:0] hi, input logic [31:0] lo);
      check({name, "_hi"}, HI, hi);
      check({name, "_lo"}, LO, lo);
   endtask

   initial begin
      #600000;
      $display("[TB] FAIL watchdog cycle=%0d actual=running required=finished", cycle);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      logic [31:0] a;
      logic [31:0] b;
      rst   = 1'b1;
      start = 1'b0;
      op    = 3'b000;
      SrcA  = '0;
      SrcB  = '0;
      idle();
      idle();
      rst = 1'b0;
      idle();

      runOp(3'b000, 32'd7, 32'd6);
      expectRegs("multu_7x6", 32'h0000_0000, 32'h0000_002A);
      runOp(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      expectRegs("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
      runOp(3'b001, 32'd100, 32'd7);
      expectRegs("divu_100_7", 32'h0000_0002, 32'h0000_000E);
      runOp(3'b001, 32'h1234_5678, 32'd0);
      expectRegs("divu_by_zero", 32'h1234_5678, 32'hFFFF_FFFF);

      applyStimulus(1'b1, 3'b001, 32'd1000, 32'd10);
      applyStimulus(1'b1, 3'b100, 32'h0000_DEAD, 32'd0);
      applyStimulus(1'b1, 3'b000, 32'd5, 32'd5);
      waitDone();
      idle();
      expectRegs("busy_protect", 32'h0000_0000, 32'h0000_0064);

      applyStimulus(1'b1, 3'b000, 32'd2, 32'd3);
      waitDone();
      applyStimulus(1'b1, 3'b101, 32'h0000_0055, 32'd0);
      idle();
      expectRegs("back_to_back", 32'h0000_0000, 32'h0000_0055);

      applyStimulus(1'b1, 3'b110, 32'h1111_1111, 32'd1);
      applyStimulus(1'b1, 3'b111, 32'h2222_2222, 32'd1);
      idle();
      expectRegs("undefined_op", 32'h0000_0000, 32'h0000_0055);

      applyStimulus(1'b1, 3'b000, 32'd3, 32'd3);
      c = cycle;
      while (cycle < c + 11) idle();
      rst = 1'b1;
      sbQ.delete();
      mPending = 1'b0;
      mVisHi   = '0;
      mVisLo   = '0;
      idle();
      idle();
      expectRegs("reset_midop", 32'h0000_0000, 32'h0000_0000);
      rst = 1'b0;
      idle();
      idle();
      runOp(3'b000, 32'd3, 32'd3);
      expectRegs("after_reset", 32'h0000_0000, 32'h0000_0009);

`ifdef SIGNED_MULDIV_EN
      runOp(3'b011, 32'hFFFF_FFF9, 32'd2);
      expectRegs("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      runOp(3'b010, 32'hFFFF_FFFD, 32'd5);
      expectRegs("mult_m3_5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`else
      applyStimulus(1'b1, 3'b010, 32'd3, 32'd5);
      applyStimulus(1'b1, 3'b011, 32'd9, 32'd2);
      idle();
      expectRegs("signed_disabled", 32'h0000_0000, 32'h0000_0009);
`endif

      for (int i = 0; i < 1500; i++) begin
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 7))
            0: b = '0;
            1, 2: b = 32'($urandom_range(1, 20));
            3: a = 32'($urandom_range(0, 200));
            default: ;
         endcase
         applyStimulus($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), a, b);
      end
      waitDone();
      idle();
      idle();
      check("scoreboard_drained", 32'(sbQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
